// File: rtl/ring_counter_ctrl.sv
// ---------------------------------------------------------------------------
// ring_counter_ctrl
//
// Parametrised ring / twisted-ring (Johnson) counter used as a sequencer or
// phase generator for downstream strobes. The mode, direction and enable
// inputs can change at run time. A synchronous parallel load is available.
// The block flags states that are not legal for the current mode and can
// optionally recover from them. It also emits a one-cycle wrap pulse each
// time the sequence returns to its seed.
//
// Parameters
//   WIDTH        register width (>= 2)
//   SEED_POS     index of the single 1 in the seed / reset value
//   SELF_CORRECT 1: an enabled step from an illegal state reloads the seed
//                0: shift blindly regardless of legality
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   en       in   step enable
//   dir      in   0 = rotate right (toward LSB), 1 = rotate left
//   mode     in   0 = one-hot ring, 1 = Johnson
//   load     in   synchronous load strobe (priority over en)
//   load_val in   value written on load, unchecked
//   count    out  registered counter state
//   wrap     out  registered one-cycle pulse on return to the seed
//   illegal  out  combinational: count is not legal for the current mode
// ---------------------------------------------------------------------------
module ring_counter_ctrl #(
  parameter int WIDTH        = 4,
  parameter int SEED_POS     = WIDTH - 1,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED = ONE << SEED_POS;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             ring_legal;
  logic             johnson_legal;
  logic [WIDTH-1:0] probe;

  // Ring legality: exactly one bit set. x & (x-1) clears the lowest set bit.
  assign ring_legal = (count != '0) && ((count & (count - ONE)) == '0);

  // Johnson legality: walk the seed's orbit, which is a constant once the
  // parameters are fixed, so this reduces to a set of equality compares.
  // Left steps are the exact inverse of right steps, so the right-step
  // orbit already covers every state reachable in either direction.
  // NOTE: probe is a blocking temporary inside combinational logic. Each
  // iteration must see the value written by the previous one, and every
  // variable is given a default first so that no latch is inferred.
  always_comb begin
    johnson_legal = 1'b0;
    probe         = SEED;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (count == probe) johnson_legal = 1'b1;
      probe = {~probe[0], probe[WIDTH-1:1]};
    end
  end

  assign illegal = mode ? !johnson_legal : !ring_legal;

  // Candidate shifted value for the current mode and direction.
  always_comb begin
    shifted = count;
    unique case ({mode, dir})
      2'b00:   shifted = {count[0], count[WIDTH-1:1]};
      2'b01:   shifted = {count[WIDTH-2:0], count[WIDTH-1]};
      2'b10:   shifted = {~count[0], count[WIDTH-1:1]};
      default: shifted = {count[WIDTH-2:0], ~count[WIDTH-1]};
    endcase
  end

  // Update priority is load > en > hold. A wrap is issued only when a legal
  // state steps onto the seed. A step that recovers from an illegal state
  // never wraps, whether or not it lands on the seed.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = load_val;
    end else if (en) begin
      if (illegal && SELF_CORRECT) begin
        next_count = SEED;
      end else begin
        next_count = shifted;
        next_wrap  = !illegal && (shifted == SEED);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so that every flop
  // samples pre-edge values. The reset value is the seed, not zero, because
  // all-zeros is not a legal ring state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= SEED;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

endmodule

// File: tb/tb_ring_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ring_counter_ctrl
//
// Directed testbench for ring_counter_ctrl with WIDTH = 4 and seed 4'b1000.
// dut uses self-correction. dut_nc shares every input with dut but has
// SELF_CORRECT = 0, which exposes the blind-shift path.
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ring_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count,   count_nc;
  logic       wrap,    wrap_nc;
  logic       illegal, illegal_nc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ring_counter_ctrl #(.WIDTH(4), .SEED_POS(3), .SELF_CORRECT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .illegal(illegal)
  );

  ring_counter_ctrl #(.WIDTH(4), .SEED_POS(3), .SELF_CORRECT(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .count(count_nc), .wrap(wrap_nc), .illegal(illegal_nc)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [3:0] c,
                              input logic w, input logic il);
    check({tag, ".count"},   32'(count),   32'(c));
    check({tag, ".wrap"},    32'(wrap),    32'(w));
    check({tag, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset away from any clock edge. The call is made 1 unit after an
  // edge and returns 3 units after it.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
    load_val = 4'b0000;
    #2;
    expect_state("reset", 4'b1000, 1'b0, 1'b0);
    #5;
    rst = 1'b0;

    // 1. Ring right sweep; the sequence wraps on its return to 1000.
    en = 1'b1;
    step(); expect_state("t1.s1", 4'b0100, 1'b0, 1'b0);
    step(); expect_state("t1.s2", 4'b0010, 1'b0, 1'b0);
    step(); expect_state("t1.s3", 4'b0001, 1'b0, 1'b0);
    step(); expect_state("t1.s4", 4'b1000, 1'b1, 1'b0);
    step(); expect_state("t1.s5", 4'b0100, 1'b0, 1'b0);

    // 2. Ring left with an enable gap.
    do_reset(); dir = 1'b1; en = 1'b1;
    step(); expect_state("t2.s1", 4'b0001, 1'b0, 1'b0);
    en = 1'b0;
    step(); expect_state("t2.hold", 4'b0001, 1'b0, 1'b0);
    en = 1'b1;
    step(); expect_state("t2.s2", 4'b0010, 1'b0, 1'b0);
    step(); expect_state("t2.s3", 4'b0100, 1'b0, 1'b0);
    step(); expect_state("t2.s4", 4'b1000, 1'b1, 1'b0);

    // 3. Johnson right from reset.
    do_reset(); mode = 1'b1; dir = 1'b0; en = 1'b1;
    step(); expect_state("t3.s1", 4'b1100, 1'b0, 1'b0);
    step(); expect_state("t3.s2", 4'b1110, 1'b0, 1'b0);
    step(); expect_state("t3.s3", 4'b1111, 1'b0, 1'b0);
    step(); expect_state("t3.s4", 4'b0111, 1'b0, 1'b0);
    step(); expect_state("t3.s5", 4'b0011, 1'b0, 1'b0);
    step(); expect_state("t3.s6", 4'b0001, 1'b0, 1'b0);
    step(); expect_state("t3.s7", 4'b0000, 1'b0, 1'b0);
    step(); expect_state("t3.s8", 4'b1000, 1'b1, 1'b0);

    // 4. Load has priority over en. The next step either corrects to the
    //    seed or shifts blindly, depending on SELF_CORRECT.
    do_reset(); mode = 1'b0; dir = 1'b0; en = 1'b1;
    load = 1'b1; load_val = 4'b0110;
    step(); expect_state("t4.load", 4'b0110, 1'b0, 1'b1);
    check("t4.nc_load", 32'(count_nc), 32'(4'b0110));
    load = 1'b0;
    step(); expect_state("t4.fix", 4'b1000, 1'b0, 1'b0);
    check("t4.nc_count",   32'(count_nc),   32'(4'b0011));
    check("t4.nc_wrap",    32'(wrap_nc),    32'(1'b0));
    check("t4.nc_illegal", 32'(illegal_nc), 32'(1'b1));

    // 5. Mode switch to Johnson from ring state 0100, then a reversal.
    do_reset(); mode = 1'b0; dir = 1'b0; en = 1'b1;
    step(); expect_state("t5.ring", 4'b0100, 1'b0, 1'b0);
    en = 1'b0; mode = 1'b1;
    #1;
    check("t5.illegal_comb", 32'(illegal), 32'(1'b1));
    en = 1'b1;
    step(); expect_state("t5.fix", 4'b1000, 1'b0, 1'b0);
    step(); expect_state("t5.j1", 4'b1100, 1'b0, 1'b0);
    step(); expect_state("t5.j2", 4'b1110, 1'b0, 1'b0);
    dir = 1'b1;
    step(); expect_state("t5.rev1", 4'b1100, 1'b0, 1'b0);
    step(); expect_state("t5.rev2", 4'b1000, 1'b1, 1'b0);

    // 6. Asynchronous reset mid-sequence overrides load and en.
    do_reset(); mode = 1'b0; dir = 1'b0; en = 1'b1;
    step(); expect_state("t6.s1", 4'b0100, 1'b0, 1'b0);
    step(); expect_state("t6.s2", 4'b0010, 1'b0, 1'b0);
    #2;
    rst = 1'b1; load = 1'b1; load_val = 4'b0110;
    #1;
    expect_state("t6.async", 4'b1000, 1'b0, 1'b0);
    step(); expect_state("t6.held", 4'b1000, 1'b0, 1'b0);
    #2;
    rst = 1'b0; load = 1'b0;
    step(); expect_state("t6.after", 4'b0100, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
